// File: rtl/mac_pkg.sv
// Shared types, default sizes and helpers for the product accumulator.
package mac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned LEN_W_DEF = 8;

  // A frame length of zero stands for the largest frame, 2^len_w products.
  function automatic int unsigned eff_len(input int unsigned len,
                                          input int unsigned len_w);
    return (len == 0) ? (32'd1 << len_w) : len;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: clamps at all-ones and reports when it did.
module sat_add #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         sat_o
);

  logic [W:0] full;

  // One-bit-wider add; the carry out decides saturation.
  always_comb begin
    full  = {1'b0, a_i} + {1'b0, b_i};
    sat_o = full[W];
    sum_o = full[W] ? '1 : full[W-1:0];
  end

endmodule

// File: rtl/prod_accum8.sv
// Frame accumulator for the 8-bit product stream: sums a programmable
// number of products per frame with saturation and hands each frame sum
// to a one-entry valid/ready output register.
module prod_accum8
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       p_i,
  input  logic             valid_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sat_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             ovr_o
);

  localparam int unsigned CNT_W = LEN_W + 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             fsat_q, fsat_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             done;
  logic [ACC_W-1:0] fin_sum;
  logic             fin_sat;

  assign p_ext   = {{(ACC_W-8){1'b0}}, p_i};
  assign len_eff = CNT_W'(eff_len(32'(len_i), LEN_W));
  assign cnt_inc = cnt_q + CNT_W'(1);

  sat_add #(.W(ACC_W)) u_add (
    .a_i   (acc_q),
    .b_i   (p_ext),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  // Frame FSM: starts a frame in IDLE, accumulates in ACC, flags completion.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    fsat_d  = fsat_q;
    done    = 1'b0;
    fin_sum = '0;
    fin_sat = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          len_d = len_eff;
          if (len_eff == CNT_W'(1)) begin
            // A one-product frame completes without entering ACC.
            done    = 1'b1;
            fin_sum = p_ext;
            acc_d   = '0;
            cnt_d   = '0;
            fsat_d  = 1'b0;
          end else begin
            acc_d   = p_ext;
            cnt_d   = CNT_W'(1);
            fsat_d  = 1'b0;
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (valid_i) begin
          if (cnt_inc == len_q) begin
            done    = 1'b1;
            fin_sum = add_sum;
            fin_sat = fsat_q | add_sat;
            acc_d   = '0;
            cnt_d   = '0;
            fsat_d  = 1'b0;
            state_d = IDLE;
          end else begin
            acc_d  = add_sum;
            cnt_d  = cnt_inc;
            fsat_d = fsat_q | add_sat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on completion when free or being drained, else flag overrun.
  always_comb begin
    sum_d   = sum_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (done) begin
      if (!valid_q || ready_i) begin
        sum_d   = fin_sum;
        sat_d   = fin_sat;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      fsat_q  <= 1'b0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      fsat_q  <= fsat_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sum_o   = sum_q;
  assign sat_o   = sat_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == ACC);
  assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_prod_accum8.sv
// Self-checking bench for prod_accum8: a 16-bit and a 10-bit accumulator
// share one stimulus stream and are compared against a frame-level model.
module tb_prod_accum8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] p_i = '0;
  logic       valid_i = 1'b0;
  logic [7:0] len_i = '0;
  logic       ready_i = 1'b0;

  logic [15:0] sum_a;
  logic        sat_a, valid_a, busy_a, ovr_a;
  logic [9:0]  sum_b;
  logic        sat_b, valid_b, busy_b, ovr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prod_accum8 #(.ACC_W(16), .LEN_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .p_i(p_i), .valid_i(valid_i), .len_i(len_i),
    .sum_o(sum_a), .sat_o(sat_a), .valid_o(valid_a), .ready_i(ready_i),
    .busy_o(busy_a), .ovr_o(ovr_a)
  );

  prod_accum8 #(.ACC_W(10), .LEN_W(8)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .p_i(p_i), .valid_i(valid_i), .len_i(len_i),
    .sum_o(sum_b), .sat_o(sat_b), .valid_o(valid_b), .ready_i(ready_i),
    .busy_o(busy_b), .ovr_o(ovr_b)
  );

  // Frame-level reference: plain running total per frame; the saturated sum
  // is min(total, max) and the frame saturated iff total exceeded max.
  int unsigned m_tot = 0, m_cnt = 0, m_len = 0;
  bit          m_busy = 0;
  bit          mv = 0, movr = 0, mst16 = 0, mst10 = 0;
  int unsigned ms16 = 0, ms10 = 0;

  always @(posedge clk) begin : model
    int unsigned tot, cnt, len, fin;
    bit busy, done;
    tot = m_tot; cnt = m_cnt; len = m_len; busy = m_busy; done = 0; fin = 0;
    if (!rst_n) begin
      m_tot <= 0; m_cnt <= 0; m_len <= 0; m_busy <= 0;
      mv <= 0; movr <= 0; ms16 <= 0; ms10 <= 0; mst16 <= 0; mst10 <= 0;
    end else begin
      if (valid_i) begin
        if (!busy) begin
          len = (len_i == 0) ? 256 : int'(len_i);
          tot = p_i;
          cnt = 1;
        end else begin
          tot = tot + p_i;
          cnt = cnt + 1;
        end
        if (cnt == len) begin
          done = 1; fin = tot; busy = 0; tot = 0; cnt = 0;
        end else begin
          busy = 1;
        end
      end
      if (done) begin
        if (!mv || ready_i) begin
          mv    <= 1;
          ms16  <= (fin > 65535) ? 65535 : fin;
          mst16 <= (fin > 65535);
          ms10  <= (fin > 1023) ? 1023 : fin;
          mst10 <= (fin > 1023);
        end else begin
          movr <= 1;
        end
      end else if (mv && ready_i) begin
        mv <= 0;
      end
      m_tot <= tot; m_cnt <= cnt; m_len <= len; m_busy <= busy;
    end
  end

  logic [33:0] obs, expv;
  assign obs  = {valid_a, sum_a, sat_a, valid_b, sum_b, sat_b,
                 busy_a, busy_b, ovr_a, ovr_b};
  assign expv = {mv, ms16[15:0], mst16, mv, ms10[9:0], mst10,
                 m_busy, m_busy, movr, movr};

  task automatic step(input bit rn, input bit v, input logic [7:0] p,
                      input logic [7:0] l, input bit r);
    rst_n = rn; valid_i = v; p_i = p; len_i = l; ready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 1, 8'd200, 8'd3, 0);
    step(0, 0, 8'd0, 8'd0, 0);
    checks++;
    if (obs !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", obs, 34'd0);
    end
  endtask

  task automatic test_basic();
    logic [7:0] prods [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    int busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, prods[i], 8'd4, 1);
      if (busy_a) busy_cycles++;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL basic_step%0d: got %h want %h", i, obs, expv);
      end
      if (i < 3) begin
        checks++;
        if (valid_a !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid%0d: got %b want 0", i, valid_a);
        end
      end
    end
    checks++;
    if (valid_a !== 1'b1 || sum_a !== 16'd100 || sat_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: got v=%b sum=%0d sat=%b want v=1 sum=100 sat=0",
               valid_a, sum_a, sat_a);
    end
    checks++;
    if (busy_cycles != 3) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d want 3", busy_cycles);
    end
    step(1, 0, 8'd0, 8'd0, 1);
    checks++;
    if (valid_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_drop: got %b want 0", valid_a);
    end
  endtask

  task automatic test_gaps();
    // Valid pattern: products with 0, 3 and 1 idle cycles between them.
    bit         vs [8] = '{1, 1, 0, 0, 0, 1, 0, 1};
    logic [7:0] ps [8] = '{8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd30, 8'd0, 8'd40};
    for (int i = 0; i < 8; i++) begin
      step(1, vs[i], ps[i], 8'd4, 1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL gaps_step%0d: got %h want %h", i, obs, expv);
      end
    end
    checks++;
    if (valid_a !== 1'b1 || sum_a !== 16'd100) begin
      errors++;
      $display("FAIL gaps_sum: got v=%b sum=%0d want v=1 sum=100", valid_a, sum_a);
    end
  endtask

  task automatic test_sat();
    for (int i = 0; i < 5; i++) step(1, 1, 8'd255, 8'd5, 1);
    checks++;
    if (sum_b !== 10'd1023 || sat_b !== 1'b1 || sum_a !== 16'd1275 || sat_a !== 1'b0) begin
      errors++;
      $display("FAIL sat_frame: got s10=%0d/%b s16=%0d/%b want 1023/1 1275/0",
               sum_b, sat_b, sum_a, sat_a);
    end
    step(1, 1, 8'd3, 8'd1, 1);
    checks++;
    if (valid_b !== 1'b1 || sum_b !== 10'd3 || sat_b !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear_next: got v=%b sum=%0d sat=%b want v=1 sum=3 sat=0",
               valid_b, sum_b, sat_b);
    end
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL sat_model: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_long_back_to_back();
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 8'd255, 8'd0, 1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL long_step%0d: got %h want %h", i, obs, expv);
      end
    end
    checks++;
    if (valid_a !== 1'b1 || sum_a !== 16'd65280 || sat_a !== 1'b0) begin
      errors++;
      $display("FAIL long_sum: got v=%b sum=%0d sat=%b want v=1 sum=65280 sat=0",
               valid_a, sum_a, sat_a);
    end
    step(1, 1, 8'd9, 8'd1, 1);
    checks++;
    if (valid_a !== 1'b1 || sum_a !== 16'd9 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL long_b2b: got v=%b sum=%0d busy=%b want v=1 sum=9 busy=0",
               valid_a, sum_a, busy_a);
    end
    step(1, 0, 8'd0, 8'd0, 1);
  endtask

  task automatic test_overrun();
    step(0, 0, 8'd0, 8'd0, 0);
    step(1, 1, 8'd7, 8'd1, 0);
    step(1, 1, 8'd9, 8'd1, 0);
    step(1, 0, 8'd0, 8'd0, 0);
    checks++;
    if (valid_a !== 1'b1 || sum_a !== 16'd7 || ovr_a !== 1'b1 || ovr_b !== 1'b1) begin
      errors++;
      $display("FAIL ovr_hold: got v=%b sum=%0d ovr=%b/%b want v=1 sum=7 ovr=1/1",
               valid_a, sum_a, ovr_a, ovr_b);
    end
    step(1, 0, 8'd0, 8'd0, 1);
    checks++;
    if (valid_a !== 1'b0 || sum_a !== 16'd7 || ovr_a !== 1'b1) begin
      errors++;
      $display("FAIL ovr_accept: got v=%b sum=%0d ovr=%b want v=0 sum=7 ovr=1",
               valid_a, sum_a, ovr_a);
    end
    step(1, 0, 8'd0, 8'd0, 1);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL ovr_model: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1, 1, 8'd50, 8'd4, 1);
    step(1, 1, 8'd60, 8'd4, 1);
    step(0, 0, 8'd0, 8'd0, 1);
    checks++;
    if (obs !== 34'd0) begin
      errors++;
      $display("FAIL midreset_clear: got %h want %h", obs, 34'd0);
    end
    step(1, 1, 8'd5, 8'd2, 1);
    step(1, 1, 8'd6, 8'd2, 1);
    checks++;
    if (valid_a !== 1'b1 || sum_a !== 16'd11 || sum_b !== 10'd11) begin
      errors++;
      $display("FAIL midreset_sum: got v=%b sum=%0d/%0d want v=1 sum=11/11",
               valid_a, sum_a, sum_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bit         rn, v, r;
      logic [7:0] p, l;
      rn = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 1) != 0);
      p  = 8'($urandom_range(0, 255));
      l  = ($urandom_range(0, 39) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
      step(rn, v, p, l, r);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_sat();
    test_long_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
